// File: rtl/mips_pkg.sv
// Shared opcodes, FSM state encoding and datapath control encodings for the
// multicycle MIPS controller.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_B_RT    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR  = 2'b01;
  localparam logic [1:0] ALU_B_IMM   = 2'b10;
  localparam logic [1:0] ALU_B_IMMSH = 2'b11;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    StIdle    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StMemAdr  = 4'd3,
    StMemRd   = 4'd4,
    StMemWb   = 4'd5,
    StMemWr   = 4'd6,
    StExec    = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StJump    = 4'd10,
    StAddiEx  = 4'd11,
    StAddiWb  = 4'd12,
    StIllegal = 4'd13
  } state_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode for the multicycle controller; only the FETCH-state
// IR/PC loads look at mem_ready.
module mc_output_decode
  import mips_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_src,
  output logic       illegal
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_RT;
    alu_op        = ALU_OP_ADD;
    pc_src        = PC_SRC_ALU;
    illegal       = 1'b0;

    unique case (state)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      // Branch target is precomputed here while the register file is read.
      StDecode: alu_src_b = ALU_B_IMMSH;
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      StMemRd: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      StExec: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNCT;
      end
      StAluWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
      end
      StJump: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      StAddiEx: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      StAddiWb:  reg_write = 1'b1;
      StIllegal: illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: state register, next-state logic and the
// retired-instruction counter; outputs come from mc_output_decode.
module multicycle_controller
  import mips_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_src,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      StIdle:   state_d = StFetch;
      StFetch:  state_d = mem_ready ? StDecode : StFetch;
      StDecode: begin
        unique case (opcode)
          OP_RTYPE:     state_d = StExec;
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_BEQ:       state_d = StBranch;
          OP_J:         state_d = StJump;
          OP_ADDI:      state_d = StAddiEx;
          default:      state_d = StIllegal;
        endcase
      end
      StMemAdr: state_d = (opcode == OP_LW) ? StMemRd : StMemWr;
      StMemRd:  state_d = mem_ready ? StMemWb : StMemRd;
      StMemWr: begin
        state_d = mem_ready ? StFetch : StMemWr;
        retire  = mem_ready;
      end
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
      StMemWb, StAluWb, StBranch, StJump, StAddiWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      // Illegal instructions are not counted as retired.
      StIllegal: state_d = StFetch;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) count_q <= count_q + CNT_W'(1);
    end
  end

  assign state       = state_q;
  assign instr_count = count_q;

  mc_output_decode u_decode (
    .state         (state_q),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal       (illegal)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instructions are expanded into a per-cycle
// trace of expected states, and every cycle is compared against that trace.
module tb_multicycle_controller;

  localparam int CW = 8;

  localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [5:0]    opcode = '0;
  logic          mem_ready = 1'b0;
  logic          pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic          mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0]    alu_src_b, alu_op, pc_src;
  logic [3:0]    state;
  logic [CW-1:0] instr_count;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_src        (pc_src),
    .illegal       (illegal),
    .state         (state),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         st;
    bit         mr;
    logic [5:0] op;
    bit         ret;
    bit         rs;
  } cyc_t;

  cyc_t        trace[$];
  cyc_t        cur;
  bit          chk_valid = 1'b0;
  int unsigned cnt_model = 0;
  int unsigned tot = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  logic [16:0] act_ctl;
  assign act_ctl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                    mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                    pc_src, illegal};

  // Control table straight from the state descriptions; same field order as act_ctl.
  function automatic logic [16:0] exp_ctl(int st, bit mr);
    logic pw = 0, pwc = 0, iod = 0, mrd = 0, mwr = 0, irw = 0, m2r = 0, rd = 0;
    logic rw = 0, a = 0, ill = 0;
    logic [1:0] b = 2'b00, op = 2'b00, ps = 2'b00;
    case (st)
      1:  begin mrd = 1; b = 2'b01; irw = mr; pw = mr; end
      2:  b = 2'b11;
      3:  begin a = 1; b = 2'b10; end
      4:  begin mrd = 1; iod = 1; end
      5:  begin rw = 1; m2r = 1; end
      6:  begin mwr = 1; iod = 1; end
      7:  begin a = 1; op = 2'b10; end
      8:  begin rw = 1; rd = 1; end
      9:  begin a = 1; op = 2'b01; ps = 2'b01; pwc = 1; end
      10: begin ps = 2'b10; pw = 1; end
      11: begin a = 1; b = 2'b10; end
      12: rw = 1;
      13: ill = 1;
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, a, b, op, ps, ill};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_valid) begin
      check("state", 32'(state), 32'(cur.st));
      check("controls", 32'(act_ctl), 32'(exp_ctl(cur.st, cur.mr)));
      check("instr_count", 32'(instr_count), cnt_model);
      if (cur.ret) cnt_model = (cnt_model + 1) % (1 << CW);
    end
  end

  task automatic add(int st, bit mr, logic [5:0] op, bit ret = 1'b0, bit rs = 1'b0);
    cyc_t e;
    e.st = st; e.mr = mr; e.op = op; e.ret = ret; e.rs = rs;
    trace.push_back(e);
  endtask

  // Expand one instruction into its cycle trace; stalls are mem_ready=0 cycles.
  task automatic gen_instr(logic [5:0] op, int fs, int ms);
    for (int i = 0; i < fs; i++) add(1, 1'b0, op);
    add(1, 1'b1, op);
    add(2, 1'($urandom), op);
    case (op)
      LW: begin
        add(3, 1'($urandom), op);
        for (int i = 0; i < ms; i++) add(4, 1'b0, op);
        add(4, 1'b1, op);
        add(5, 1'($urandom), op, 1'b1);
      end
      SW: begin
        add(3, 1'($urandom), op);
        for (int i = 0; i < ms; i++) add(6, 1'b0, op);
        add(6, 1'b1, op, 1'b1);
      end
      RT:   begin add(7, 1'($urandom), op); add(8, 1'($urandom), op, 1'b1); end
      ADDI: begin add(11, 1'($urandom), op); add(12, 1'($urandom), op, 1'b1); end
      BEQ:  add(9, 1'($urandom), op, 1'b1);
      JMP:  add(10, 1'($urandom), op, 1'b1);
      default: add(13, 1'($urandom), op);
    endcase
    if (op inside {LW, SW, RT, ADDI, BEQ, JMP}) tot++;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_trace();
    cyc_t e;
    while (trace.size() > 0) begin
      e = trace.pop_front();
      rst       = !e.rs;
      opcode    = e.op;
      mem_ready = e.mr;
      cur       = e;
      chk_valid = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] o;
    case ($urandom_range(0, 6))
      0: o = RT;
      1: o = LW;
      2: o = SW;
      3: o = BEQ;
      4: o = JMP;
      5: o = ADDI;
      default: begin
        o = 6'($urandom);
        while (o inside {RT, LW, SW, BEQ, JMP, ADDI}) o = 6'($urandom);
      end
    endcase
    return o;
  endfunction

  initial begin
    #1;
    for (int i = 0; i < 3; i++) add(0, 1'($urandom), 6'($urandom), 1'b0, 1'b1);
    add(0, 1'b1, LW);
    gen_instr(LW, 0, 0);
    run_trace();
    check("count after lw", 32'(instr_count), 32'd1);

    gen_instr(SW, 0, 2);
    run_trace();
    check("count after sw", 32'(instr_count), 32'd2);

    gen_instr(BEQ, 0, 0);
    gen_instr(JMP, 1, 0);
    run_trace();
    check("count after beq+j", 32'(instr_count), 32'd4);

    gen_instr(6'b111111, 0, 0);
    run_trace();
    check("count after illegal", 32'(instr_count), 32'd4);
    gen_instr(RT, 0, 0);
    run_trace();
    check("count after rtype", 32'(instr_count), 32'd5);

    // Abort a lw while it waits in MEMRD.
    add(1, 1'b1, LW);
    add(2, 1'b1, LW);
    add(3, 1'b0, LW);
    add(4, 1'b0, LW);
    add(4, 1'b0, LW);
    run_trace();
    chk_valid = 1'b0;
    mem_ready = 1'b0;
    #2;
    check("memrd before reset", 32'(mem_read), 32'd1);
    check("state before reset", 32'(state), 32'd4);
    rst = 1'b0;
    #1;
    check("mem_read on reset", 32'(mem_read), 32'd0);
    check("state on reset", 32'(state), 32'd0);
    check("reg_write on reset", 32'(reg_write), 32'd0);
    check("count on reset", 32'(instr_count), 32'd0);
    cnt_model = 0;
    tot = 0;
    @(posedge clk);
    #1;
    add(0, 1'b0, ADDI, 1'b0, 1'b1);
    add(0, 1'b1, ADDI);
    gen_instr(ADDI, 0, 0);
    run_trace();
    check("count after addi", 32'(instr_count), 32'd1);

    // Enough retirements to wrap the narrow counter several times.
    for (int n = 0; n < 1400; n++) begin
      gen_instr(rand_op(), ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3),
                ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3));
      run_trace();
    end
    check("count after random", 32'(instr_count), tot % (1 << CW));
    check("wrapped at least once", 32'(tot >= (1 << CW)), 32'd1);

    chk_valid = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
